adder_tree_accum_ctrl: RTL and testbench

Sequencer that drives one pipelined adder tree and turns it into a multi-cycle dot-product/convolution accumulator. It accepts a stream of `len` input vectors over a valid/ready handshake and feeds each vector to the tree. It tracks which tree results are valid, sums them into a WIDTH-bit accumulator, and presents one result per job on a valid/ready output. It sits between the operand fetch logic and the adder tree instance in the convolution datapath.

---
 rtl/adder_tree_accum_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_adder_tree_accum_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum_ctrl.sv
// ---------------------------------------------------------------------------
// adder_tree_accum_ctrl
//
// Purpose:
//   Sequencer wrapped around one external pipelined adder tree. A job of
//   `len` input vectors arrives over a valid/ready handshake. Each accepted
//   vector is forwarded to the tree. The controller tracks which tree results
//   are meaningful and sums them into a WIDTH-bit wrap-around accumulator.
//   The finished sum is then offered on a valid/ready result port. The block
//   turns a single-shot adder tree into a multi-cycle dot-product /
//   convolution accumulator.
//
// Parameters:
//   WIDTH      lane and result width in bits
//   INPUT_NUM  lanes per vector (must match the tree's input count)
//   TREE_LAT   cycles from tree_in sampled to tree_res valid (>= 1)
//   LEN_W      width of the job-length field
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      job start, only looked at in IDLE
//   i_len        vectors in the job, latched on start
//   i_abort      synchronous cancel, wins over every other transition
//   o_busy       state is not IDLE
//   o_done       one-cycle pulse when the result is consumed
//   o_cfg_err    one-cycle pulse when start arrives with len == 0
//   i_in_valid   input vector valid
//   o_in_ready   controller accepts a vector (function of state only)
//   i_in_data    input vector, lane i at [i*WIDTH +: WIDTH]
//   o_tree_in    drives the tree's indata (zero when nothing is accepted)
//   i_tree_res   tree's res output
//   o_out_valid  accumulated result valid
//   i_out_ready  downstream accepts the result
//   o_out_data   accumulated result
// ---------------------------------------------------------------------------
module adder_tree_accum_ctrl #(
  parameter int WIDTH     = 32,
  parameter int INPUT_NUM = 4,
  parameter int TREE_LAT  = 1,
  parameter int LEN_W     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_cfg_err,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [INPUT_NUM*WIDTH-1:0] i_in_data,
  output logic [INPUT_NUM*WIDTH-1:0] o_tree_in,
  input  logic [WIDTH-1:0]           i_tree_res,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issue_cnt;
  logic [LEN_W-1:0]    r_retire_cnt;
  logic [WIDTH-1:0]    r_acc;
  logic [TREE_LAT-1:0] r_vsr;

  logic                w_accept;
  logic                w_retire;
  logic                w_len_zero;
  logic                w_start_ok;
  logic                w_last_issue;
  logic                w_last_retire;
  logic                w_all_retired;

  // Handshake and bookkeeping terms. in_ready is derived from the state
  // alone, so an accept is simply "RUN and the source offers a vector".
  assign w_accept      = i_in_valid && (r_state == S_RUN);
  assign w_retire      = r_vsr[TREE_LAT-1];
  assign w_len_zero    = (i_len == '0);
  assign w_start_ok    = (r_state == S_IDLE) && i_start && !w_len_zero;
  assign w_last_issue  = w_accept && ((r_issue_cnt + LEN_W'(1)) == r_len);
  assign w_last_retire = w_retire && ((r_retire_cnt + LEN_W'(1)) == r_len);

  // Leaving for OUT happens on the edge that accumulates the final result,
  // not one cycle later when the counter shows it.
  assign w_all_retired = (r_retire_cnt == r_len) || w_last_retire;

  // The tree sees the vector only in a cycle where it is really accepted;
  // otherwise it sees zeros so nothing stale flows down its pipeline.
  assign o_tree_in  = w_accept ? i_in_data : '0;
  assign o_out_data = r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs. abort is applied last so it overrides
  // start, out_ready and the completion conditions, and it also suppresses
  // the done / cfg_err pulses of the cycle it appears in.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_done      = 1'b0;
    o_cfg_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_len_zero) begin
            o_cfg_err = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
        // The final retirement can only coincide with the final issue if
        // the tree hid no latency; checking it keeps the OUT hand-off
        // independent of which state the last retirement lands in.
        if (w_last_issue) begin
          w_state_nxt = w_last_retire ? S_OUT : S_DRAIN;
        end
      end

      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_all_retired) begin
          w_state_nxt = S_OUT;
        end
      end

      S_OUT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          o_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      o_done      = 1'b0;
      o_cfg_err   = 1'b0;
    end
  end

  // Job length, issue / retire counters and the accumulator. A new job
  // clears everything; otherwise issue and retirement advance independently
  // because retirements overlap with issue while the tree pipeline fills.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_acc        <= '0;
    end else if (i_abort) begin
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_acc        <= '0;
    end else if (w_start_ok) begin
      r_len        <= i_len;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_acc        <= '0;
    end else begin
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      end
      if (w_retire) begin
        r_acc        <= r_acc + i_tree_res;
        r_retire_cnt <= r_retire_cnt + LEN_W'(1);
      end
    end
  end

  // Valid shift register mirroring the tree pipeline: a 1 enters with each
  // accept and emerges exactly when the tree presents that vector's sum.
  generate
    if (TREE_LAT == 1) begin : g_vsr_single
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_vsr <= '0;
        end else if (i_abort) begin
          r_vsr <= '0;
        end else begin
          r_vsr <= w_accept;
        end
      end
    end else begin : g_vsr_multi
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_vsr <= '0;
        end else if (i_abort) begin
          r_vsr <= '0;
        end else begin
          r_vsr <= {r_vsr[TREE_LAT-2:0], w_accept};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Testbench for adder_tree_accum_ctrl. Two instances are built: one with a
// single-cycle tree and one with a three-cycle tree. Each has a behavioural
// tree model. Only the selected instance sees live stimulus. The reference
// model works at job level: the expected result is the plain sum of every
// element of every vector. The expected result cycle follows from the
// first-accept / gap / latency rules.
module tb_adder_tree_accum_ctrl;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int LW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nCompared   = 0;
   int nMismatched = 0;

   int sel = 0;
   int lat = 1;

   // Shared stimulus, gated onto the selected instance
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          abort;
   logic          inValid;
   logic [N*W-1:0] inData;
   logic          outReady;

   logic start0, start1, abort0, abort1, inValid0, inValid1, outReady0, outReady1;
   assign start0    = (sel == 0) && start;
   assign start1    = (sel == 1) && start;
   assign abort0    = (sel == 0) && abort;
   assign abort1    = (sel == 1) && abort;
   assign inValid0  = (sel == 0) && inValid;
   assign inValid1  = (sel == 1) && inValid;
   assign outReady0 = (sel == 0) && outReady;
   assign outReady1 = (sel == 1) && outReady;

   logic busy0, done0, cfgErr0, inReady0, outValid0;
   logic busy1, done1, cfgErr1, inReady1, outValid1;
   logic [N*W-1:0] treeIn0, treeIn1;
   logic [W-1:0]   treeRes0, treeRes1, outData0, outData1;

   adder_tree_accum_ctrl #(.WIDTH(W), .INPUT_NUM(N), .TREE_LAT(1), .LEN_W(LW)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start0), .i_len(len), .i_abort(abort0),
      .o_busy(busy0), .o_done(done0), .o_cfg_err(cfgErr0),
      .i_in_valid(inValid0), .o_in_ready(inReady0), .i_in_data(inData),
      .o_tree_in(treeIn0), .i_tree_res(treeRes0),
      .o_out_valid(outValid0), .i_out_ready(outReady0), .o_out_data(outData0)
   );

   adder_tree_accum_ctrl #(.WIDTH(W), .INPUT_NUM(N), .TREE_LAT(3), .LEN_W(LW)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .i_len(len), .i_abort(abort1),
      .o_busy(busy1), .o_done(done1), .o_cfg_err(cfgErr1),
      .i_in_valid(inValid1), .o_in_ready(inReady1), .i_in_data(inData),
      .o_tree_in(treeIn1), .i_tree_res(treeRes1),
      .o_out_valid(outValid1), .i_out_ready(outReady1), .o_out_data(outData1)
   );

   // View of the selected instance
   logic busy, done, cfgErr, inReady, outValid;
   logic [N*W-1:0] treeIn;
   logic [W-1:0]   outData;
   always_comb begin
      if (sel == 0) begin
         busy = busy0; done = done0; cfgErr = cfgErr0; inReady = inReady0;
         outValid = outValid0; treeIn = treeIn0; outData = outData0;
      end else begin
         busy = busy1; done = done1; cfgErr = cfgErr1; inReady = inReady1;
         outValid = outValid1; treeIn = treeIn1; outData = outData1;
      end
   end

   function automatic logic [W-1:0] laneSum(input logic [N*W-1:0] v);
      logic [W-1:0] s;
      s = '0;
      for (int k = 0; k < N; k++) s = s + v[k*W +: W];
      return s;
   endfunction

   function automatic logic [N*W-1:0] vec4(input logic [W-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   // Behavioural adder trees: plain registered pipelines of the lane sum
   logic [W-1:0] treePipe0;
   logic [W-1:0] treePipe1 [3];
   always @(posedge clk) begin
      treePipe0    <= laneSum(treeIn0);
      treePipe1[0] <= laneSum(treeIn1);
      treePipe1[1] <= treePipe1[0];
      treePipe1[2] <= treePipe1[1];
   end
   assign treeRes0 = treePipe0;
   assign treeRes1 = treePipe1[2];

   // Job description and observations
   logic [N*W-1:0] jobVec[$];
   int             jobGap[$];

   int           startCyc, obsReadyCyc, obsFirstAcc, obsOutCyc, obsDoneCnt;
   int           obsGapBad, obsTreeBad, obsUnstable, obsOvCycles, expOutCyc;
   logic         obsPostBusy, obsFinished;
   logic [W-1:0] obsResult, expResult;

   // Runs one job: drives vectors with the listed gaps, holds out_ready low
   // for outWait OUT cycles, then records what happened and what the job
   // model expects.
   task automatic runJob(input int n, input int outWait);
      int           idx, gapLeft, ovCnt, gapSum;
      logic         finished;
      logic [W-1:0] firstOut;
      logic [N*W-1:0] v;
      obsReadyCyc = -1; obsFirstAcc = -1; obsOutCyc = -1; obsDoneCnt = 0;
      obsGapBad = 0; obsTreeBad = 0; obsUnstable = 0;
      firstOut = '0; finished = 1'b0; idx = 0; gapLeft = 0; ovCnt = 0;
      @(negedge clk);
      start = 1'b1; len = LW'(n); inValid = 1'b0; outReady = 1'b0; abort = 1'b0;
      startCyc = cyc;
      for (int c = 0; c < 3000 && !finished; c++) begin
         @(negedge clk);
         start = 1'b0;
         inValid = (idx < n) && (gapLeft == 0);
         if (inValid) inData = jobVec[idx];
         else inData = {$urandom, $urandom, $urandom, $urandom};
         outReady = (ovCnt >= outWait);
         #1;
         if (inReady && obsReadyCyc < 0) obsReadyCyc = cyc;
         if (inValid && inReady) begin
            if (treeIn !== inData) obsTreeBad++;
            if (obsFirstAcc < 0) obsFirstAcc = cyc;
            idx++;
            gapLeft = (idx < n) ? jobGap[idx] : 0;
         end else begin
            if (treeIn !== '0) obsGapBad++;
            if (!inValid && gapLeft > 0) gapLeft--;
         end
         if (done) obsDoneCnt++;
         if (outValid) begin
            if (obsOutCyc < 0) begin
               obsOutCyc = cyc;
               firstOut  = outData;
            end else if (outData !== firstOut) begin
               obsUnstable++;
            end
            ovCnt++;
            if (outReady) finished = 1'b1;
         end
      end
      obsResult = firstOut; obsFinished = finished; obsOvCycles = ovCnt;
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b0;
      #1;
      obsPostBusy = busy;
      if (done) obsDoneCnt++;
      expResult = '0; gapSum = 0;
      for (int i = 0; i < n; i++) begin
         v = jobVec[i];
         for (int k = 0; k < N; k++) expResult = expResult + v[k*W +: W];
         if (i > 0) gapSum += jobGap[i];
      end
      expOutCyc = startCyc + 1 + (n - 1) + gapSum + lat + 1;
   endtask

   task automatic selectDut(input int d);
      sel = d;
      lat = (d == 0) ? 1 : 3;
   endtask

   task automatic loadBasic(input int gap);
      jobVec = {};
      jobGap = {};
      jobVec.push_back(vec4(1, 2, 3, 4)); jobGap.push_back(0);
      jobVec.push_back(vec4(5, 6, 7, 8)); jobGap.push_back(gap);
      jobVec.push_back(vec4(0, 0, 0, 1)); jobGap.push_back(gap);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
      inValid = 1'b0; inData = '0; outReady = 1'b0;
      @(negedge clk);
      #1;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
      nCompared++; if (cfgErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cfg_err: got %0b want 0", cfgErr); end
      nCompared++; if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %0b want 0", inReady); end
      nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %0b want 0", outValid); end
      nCompared++; if (outData !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_data: got %0h want 0", outData); end
      nCompared++; if (treeIn !== '0) begin nMismatched++; $display("[TB] FAIL reset_tree_in: got %0h want 0", treeIn); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      selectDut(0);
      loadBasic(0);
      runJob(3, 0);
      nCompared++; if (obsResult !== 32'd37) begin nMismatched++; $display("[TB] FAIL basic_result: got %0d want 37", obsResult); end
      nCompared++; if (obsReadyCyc != startCyc + 1) begin nMismatched++; $display("[TB] FAIL basic_ready_cycle: got %0d want %0d", obsReadyCyc, startCyc + 1); end
      nCompared++; if (obsOutCyc != expOutCyc) begin nMismatched++; $display("[TB] FAIL basic_out_cycle: got %0d want %0d", obsOutCyc, expOutCyc); end
      nCompared++; if (obsOutCyc - obsFirstAcc != 4) begin nMismatched++; $display("[TB] FAIL basic_latency: got %0d want 4", obsOutCyc - obsFirstAcc); end
      nCompared++; if (obsDoneCnt != 1) begin nMismatched++; $display("[TB] FAIL basic_done_count: got %0d want 1", obsDoneCnt); end
      nCompared++; if (obsPostBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_busy_after: got %0b want 0", obsPostBusy); end
      nCompared++; if (obsTreeBad != 0) begin nMismatched++; $display("[TB] FAIL basic_tree_in: got %0d bad cycles want 0", obsTreeBad); end
   endtask

   task automatic test_gaps();
      selectDut(0);
      loadBasic(2);
      runJob(3, 0);
      nCompared++; if (obsResult !== 32'd37) begin nMismatched++; $display("[TB] FAIL gaps_result: got %0d want 37", obsResult); end
      nCompared++; if (obsGapBad != 0) begin nMismatched++; $display("[TB] FAIL gaps_tree_in_zero: got %0d bad cycles want 0", obsGapBad); end
      nCompared++; if (obsOutCyc - obsFirstAcc != 8) begin nMismatched++; $display("[TB] FAIL gaps_latency: got %0d want 8", obsOutCyc - obsFirstAcc); end
   endtask

   task automatic test_wrap();
      selectDut(0);
      jobVec = {}; jobGap = {};
      repeat (2) begin
         jobVec.push_back(vec4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
         jobGap.push_back(0);
      end
      runJob(2, 0);
      nCompared++; if (obsResult !== 32'hFFFF_FFF8) begin nMismatched++; $display("[TB] FAIL wrap_result: got %0h want fffffff8", obsResult); end
      nCompared++; if (obsDoneCnt != 1) begin nMismatched++; $display("[TB] FAIL wrap_done_count: got %0d want 1", obsDoneCnt); end
   endtask

   task automatic test_cfg_err_backpressure();
      selectDut(0);
      @(negedge clk);
      start = 1'b1; len = '0;
      #1;
      nCompared++; if (cfgErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL cfg_err_pulse: got %0b want 1", cfgErr); end
      @(negedge clk);
      start = 1'b0;
      #1;
      nCompared++; if (cfgErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL cfg_err_width: got %0b want 0", cfgErr); end
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL cfg_err_busy: got %0b want 0", busy); end
      jobVec = {}; jobGap = {};
      jobVec.push_back(vec4(7, 0, 0, 0)); jobGap.push_back(0);
      runJob(1, 5);
      nCompared++; if (obsResult !== 32'd7) begin nMismatched++; $display("[TB] FAIL bp_result: got %0d want 7", obsResult); end
      nCompared++; if (obsUnstable != 0) begin nMismatched++; $display("[TB] FAIL bp_stable: got %0d changes want 0", obsUnstable); end
      nCompared++; if (obsOvCycles != 6) begin nMismatched++; $display("[TB] FAIL bp_valid_cycles: got %0d want 6", obsOvCycles); end
      nCompared++; if (obsDoneCnt != 1) begin nMismatched++; $display("[TB] FAIL bp_done_count: got %0d want 1", obsDoneCnt); end
   endtask

   task automatic test_abort();
      int bad;
      int waited;
      selectDut(0);
      @(negedge clk);
      start = 1'b1; len = 8'd4;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b0; inValid = 1'b1;
         inData = vec4(W'($urandom_range(1, 99)), 2, 3, 4);
      end
      @(negedge clk);
      inValid = 1'b0; abort = 1'b1;
      #1;
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_no_done: got %0b want 0", done); end
      @(negedge clk);
      abort = 1'b0;
      #1;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_idle: got busy %0b want 0", busy); end
      nCompared++; if (outData !== '0) begin nMismatched++; $display("[TB] FAIL abort_acc_clear: got %0h want 0", outData); end
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (outValid || done) bad++;
      end
      nCompared++; if (bad != 0) begin nMismatched++; $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", bad); end
      jobVec = {}; jobGap = {};
      jobVec.push_back(vec4(1, 1, 1, 1)); jobGap.push_back(0);
      runJob(1, 0);
      nCompared++; if (obsResult !== 32'd4) begin nMismatched++; $display("[TB] FAIL abort_next_job: got %0d want 4", obsResult); end

      // abort wins over out_ready in OUT
      @(negedge clk);
      start = 1'b1; len = 8'd1;
      @(negedge clk);
      start = 1'b0; inValid = 1'b1; inData = vec4(9, 9, 9, 9);
      waited = 0;
      do begin
         @(negedge clk);
         inValid = 1'b0;
         #1;
         waited++;
      end while (!outValid && waited < 20);
      nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_reach_out: got %0b want 1", outValid); end
      abort = 1'b1; outReady = 1'b1;
      #1;
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_over_ready: got done %0b want 0", done); end
      @(negedge clk);
      abort = 1'b0; outReady = 1'b0;
      #1;
      nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_drop_valid: got %0b want 0", outValid); end

      // abort wins over start in IDLE
      @(negedge clk);
      start = 1'b1; len = 8'd3; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_over_start: got busy %0b want 0", busy); end
   endtask

   task automatic test_async_reset();
      int bad;
      selectDut(1);
      @(negedge clk);
      start = 1'b1; len = 8'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0; inValid = 1'b1; inData = vec4(W'(i + 1), 1, 1, 1);
      end
      @(negedge clk);
      inValid = 1'b0; inData = vec4(5, 5, 5, 5);
      #1;
      nCompared++; if (busy !== 1'b1 || inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_state: got busy %0b ready %0b want 1 0", busy, inReady); end
      #1;
      rst = 1'b1;
      #1;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL arst_busy: got %0b want 0", busy); end
      nCompared++; if (outData !== '0) begin nMismatched++; $display("[TB] FAIL arst_out_data: got %0h want 0", outData); end
      nCompared++; if (outValid !== 1'b0 || inReady !== 1'b0 || done !== 1'b0 || cfgErr !== 1'b0) begin
         nMismatched++; $display("[TB] FAIL arst_flags: got valid %0b ready %0b done %0b err %0b want 0", outValid, inReady, done, cfgErr);
      end
      nCompared++; if (treeIn !== '0) begin nMismatched++; $display("[TB] FAIL arst_tree_in: got %0h want 0", treeIn); end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (outValid || busy) bad++;
      end
      nCompared++; if (bad != 0) begin nMismatched++; $display("[TB] FAIL arst_idle_after: got %0d active cycles want 0", bad); end
   endtask

   task automatic test_lat3();
      selectDut(1);
      loadBasic(0);
      runJob(3, 0);
      nCompared++; if (obsResult !== 32'd37) begin nMismatched++; $display("[TB] FAIL lat3_result: got %0d want 37", obsResult); end
      nCompared++; if (obsOutCyc - obsFirstAcc != 6) begin nMismatched++; $display("[TB] FAIL lat3_latency: got %0d want 6", obsOutCyc - obsFirstAcc); end
      nCompared++; if (obsOutCyc != expOutCyc) begin nMismatched++; $display("[TB] FAIL lat3_out_cycle: got %0d want %0d", obsOutCyc, expOutCyc); end
   endtask

   task automatic test_random();
      int n;
      for (int j = 0; j < 8; j++) begin
         selectDut(j % 2);
         n = $urandom_range(1, 12);
         jobVec = {}; jobGap = {};
         for (int i = 0; i < n; i++) begin
            jobVec.push_back({$urandom, $urandom, $urandom, $urandom});
            jobGap.push_back((i == 0) ? 0 : $urandom_range(0, 3));
         end
         runJob(n, $urandom_range(0, 3));
         nCompared++; if (obsResult !== expResult) begin nMismatched++; $display("[TB] FAIL rand%0d_result: got %0h want %0h", j, obsResult, expResult); end
         nCompared++; if (obsOutCyc != expOutCyc) begin nMismatched++; $display("[TB] FAIL rand%0d_out_cycle: got %0d want %0d", j, obsOutCyc, expOutCyc); end
         nCompared++; if (obsDoneCnt != 1 || obsPostBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rand%0d_done: got %0d pulses busy %0b want 1 0", j, obsDoneCnt, obsPostBusy); end
         nCompared++; if (obsTreeBad != 0 || obsGapBad != 0) begin nMismatched++; $display("[TB] FAIL rand%0d_tree_in: got %0d/%0d bad want 0/0", j, obsTreeBad, obsGapBad); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_wrap();
      test_cfg_err_backpressure();
      test_abort();
      test_async_reset();
      test_lat3();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
